sfm_cmd_sched: RTL

SFM_CMD_SCHED -- requirements
Module: sfm_cmd_sched

---
 rtl/sfm_cmd_sched.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/sfm_cmd_sched.sv
// rtl/sfm_cmd_sched.sv - serial flash command scheduler (auto read, JTAG and slow-control arbitration)
//
// Arbitrates flash commands from three sources and sequences each one as a
// fixed-width command pulse, an optional wait on the flash chip-select, and a
// mandatory idle gap.
//
// Ports:
//   i_clkcms     sole clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_jtag_req   level JTAG instruction lines (bit 7 unused)
//   i_sc_req     slow-control request strobe, with i_sc_op as the command bit index
//   i_sfmcs_b    flash chip-select, low while the flash interface is active
//   i_clr_err    clears o_tmo, o_sc_ovf and o_err_cnt
//   o_serfm      one-hot command bits to the flash interface
//   o_sfm_rst    reset pulse to the flash interface (auto read)
//   o_busy       high whenever the scheduler is not idle
//   o_grant_src  owner of the current op: 0 none, 1 JTAG, 2 SC, 3 auto
//   o_done       one-cycle pulse on normal completion
//   o_tmo        sticky timeout flag
//   o_sc_ovf     sticky dropped-SC-request flag
//   o_err_cnt    saturating count of timeouts and rejected SC ops
module sfm_cmd_sched #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 8,
  parameter int START_TMO = 64,
  parameter int BUSY_TMO  = 4096,
  parameter int AUTO_RD   = 1
) (
  input  logic        i_clkcms,
  input  logic        i_rst,
  input  logic [10:0] i_jtag_req,
  input  logic        i_sc_req,
  input  logic [3:0]  i_sc_op,
  input  logic        i_sfmcs_b,
  input  logic        i_clr_err,
  output logic [10:0] o_serfm,
  output logic        o_sfm_rst,
  output logic        o_busy,
  output logic [1:0]  o_grant_src,
  output logic        o_done,
  output logic        o_tmo,
  output logic        o_sc_ovf,
  output logic [7:0]  o_err_cnt
);

  localparam int CW = 16;
  localparam logic [CW-1:0] L_PULSE = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] L_GAP   = CW'(GAP_LEN - 1);
  localparam logic [CW-1:0] L_START = CW'(START_TMO - 1);
  localparam logic [CW-1:0] L_BUSY  = CW'(BUSY_TMO - 1);

  typedef enum logic [2:0] {S_IDLE, S_PULSE, S_WSTART, S_WEND, S_GAP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [10:0]   r_jtag_q;
  logic [10:0]   r_jtag_qq;
  logic [10:0]   r_pend_jt;
  logic          r_sc_pend;
  logic [3:0]    r_sc_op;
  logic          r_auto_done;
  logic          r_last_jt;
  logic          r_long;

  logic [10:0]   w_jt_rise;
  logic [3:0]    w_jt_idx;
  logic          w_jt_any;
  logic          w_auto_req;
  logic          w_pick_sc;
  logic          w_grant_auto;
  logic          w_grant_sc;
  logic          w_grant_jt;
  logic          w_sc_op_ok;
  logic          w_sc_busy;
  logic          w_sc_rej;
  logic          w_sc_ovf;
  logic          w_sc_acc;
  logic          w_tmo_ev;
  logic [1:0]    w_err_inc;
  logic [8:0]    w_err_sum;
  logic [7:0]    w_err_nxt;

  // Rising edge is taken between two registered copies so a newly asserted
  // line is pending one edge after it is first sampled; bit 7 never requests.
  assign w_jt_rise = r_jtag_q & ~r_jtag_qq & 11'h77F;
  assign w_jt_any  = |r_pend_jt;

  always_comb begin
    w_jt_idx = 4'd0;
    for (int i = 10; i >= 0; i--) begin
      if (r_pend_jt[i]) w_jt_idx = 4'(i);
    end
  end

  assign w_auto_req   = (AUTO_RD != 0) && !r_auto_done;
  // SC beats JTAG only when JTAG owned the previous grant.
  assign w_pick_sc    = r_sc_pend && (!w_jt_any || r_last_jt);
  assign w_grant_auto = (r_state == S_IDLE) && w_auto_req;
  assign w_grant_sc   = (r_state == S_IDLE) && !w_auto_req && w_pick_sc;
  assign w_grant_jt   = (r_state == S_IDLE) && !w_auto_req && !w_pick_sc && w_jt_any;

  assign w_sc_op_ok = (i_sc_op != 4'd7) && (i_sc_op <= 4'd10);
  assign w_sc_busy  = r_sc_pend || (o_grant_src == 2'b10);
  assign w_sc_rej   = i_sc_req && !w_sc_op_ok;
  assign w_sc_ovf   = i_sc_req && w_sc_op_ok && w_sc_busy;
  assign w_sc_acc   = i_sc_req && w_sc_op_ok && !w_sc_busy;

  assign w_tmo_ev = ((r_state == S_WSTART) && i_sfmcs_b && (r_cnt == L_START)) ||
                    ((r_state == S_WEND) && !i_sfmcs_b && (r_cnt == L_BUSY));

  // A timeout and a rejected SC request can land in the same cycle; a clear
  // in that cycle still leaves the new errors counted.
  assign w_err_inc = {1'b0, w_tmo_ev} + {1'b0, (w_sc_rej | w_sc_ovf)};
  assign w_err_sum = (i_clr_err ? 9'd0 : {1'b0, o_err_cnt}) + {7'd0, w_err_inc};
  assign w_err_nxt = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

  assign o_busy = (r_state != S_IDLE);

  always_ff @(posedge i_clkcms or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_jtag_q    <= '0;
      r_jtag_qq   <= '0;
      r_pend_jt   <= '0;
      r_sc_pend   <= 1'b0;
      r_sc_op     <= '0;
      r_auto_done <= 1'b0;
      r_last_jt   <= 1'b0;
      r_long      <= 1'b0;
      o_serfm     <= '0;
      o_sfm_rst   <= 1'b0;
      o_grant_src <= 2'b00;
      o_done      <= 1'b0;
      o_tmo       <= 1'b0;
      o_sc_ovf    <= 1'b0;
      o_err_cnt   <= '0;
    end else begin
      r_jtag_q  <= i_jtag_req;
      r_jtag_qq <= r_jtag_q;
      r_pend_jt <= (r_pend_jt | w_jt_rise) & ~(w_grant_jt ? (11'd1 << w_jt_idx) : 11'd0);

      if (w_grant_sc) begin
        r_sc_pend <= 1'b0;
      end else if (w_sc_acc) begin
        r_sc_pend <= 1'b1;
        r_sc_op   <= i_sc_op;
      end

      o_tmo     <= w_tmo_ev | (o_tmo & ~i_clr_err);
      o_sc_ovf  <= w_sc_ovf | (o_sc_ovf & ~i_clr_err);
      o_err_cnt <= w_err_nxt;
      o_done    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_grant_auto) begin
            o_sfm_rst   <= 1'b1;
            o_grant_src <= 2'b11;
            r_long      <= 1'b1;
            r_auto_done <= 1'b1;
            r_last_jt   <= 1'b0;
            r_state     <= S_PULSE;
          end else if (w_grant_sc) begin
            o_serfm     <= 11'd1 << r_sc_op;
            o_grant_src <= 2'b10;
            r_long      <= (r_sc_op == 4'd3);
            r_last_jt   <= 1'b0;
            r_state     <= S_PULSE;
          end else if (w_grant_jt) begin
            o_serfm     <= 11'd1 << w_jt_idx;
            o_grant_src <= 2'b01;
            r_long      <= (w_jt_idx == 4'd3);
            r_last_jt   <= 1'b1;
            r_state     <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (r_cnt == L_PULSE) begin
            o_serfm   <= '0;
            o_sfm_rst <= 1'b0;
            r_cnt     <= '0;
            if (r_long) begin
              r_state <= S_WSTART;
            end else begin
              o_done      <= 1'b1;
              o_grant_src <= 2'b00;
              r_state     <= S_GAP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WSTART: begin
          if (!i_sfmcs_b) begin
            r_cnt   <= '0;
            r_state <= S_WEND;
          end else if (r_cnt == L_START) begin
            r_cnt       <= '0;
            o_grant_src <= 2'b00;
            r_state     <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WEND: begin
          if (i_sfmcs_b) begin
            o_done      <= 1'b1;
            r_cnt       <= '0;
            o_grant_src <= 2'b00;
            r_state     <= S_GAP;
          end else if (r_cnt == L_BUSY) begin
            r_cnt       <= '0;
            o_grant_src <= 2'b00;
            r_state     <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == L_GAP) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
